// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding instruction memory
// request at a time and holds the fetched word until the downstream stage acknowledges it.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        instr_ack,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        hlt,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        halted,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] pc_plus4_r;
    logic [31:0] pc_plus4_s;
    logic [31:0] instr_r;
    logic [31:0] instr_s;
    logic        valid_r;
    logic        valid_s;
    logic        halted_r;
    logic        halted_s;
    logic        req_r;
    logic        req_s;
    logic [31:0] count_r;
    logic [31:0] count_s;

    // Redirect targets are forced to a word boundary; otherwise fall through sequentially.
    function automatic logic [31:0] next_pc(input logic        taken,
                                            input logic [31:0] target,
                                            input logic [31:0] cur);
        logic [31:0] result;
        if (taken) begin
            result = target & 32'hFFFF_FFFC;
        end else begin
            result = cur + 32'd4;
        end
        return result;
    endfunction

    // Next-state and next-register values; req_s is the request level for the coming cycle.
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        instr_s  = instr_r;
        valid_s  = valid_r;
        halted_s = halted_r;
        count_s  = count_r;
        req_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_s = ST_FETCH;
                req_s   = 1'b1;
            end
            ST_FETCH: begin
                if (imem_rvalid) begin
                    state_s = ST_HOLD;
                    instr_s = imem_rdata;
                    valid_s = 1'b1;
                end else begin
                    req_s = 1'b1;
                end
            end
            ST_HOLD: begin
                if (instr_ack) begin
                    count_s = count_r + 32'd1;
                    valid_s = 1'b0;
                    instr_s = NOP_INSTR;
                    if (hlt) begin
                        state_s  = ST_HALT;
                        halted_s = 1'b1;
                    end else begin
                        state_s = ST_FETCH;
                        req_s   = 1'b1;
                        pc_s    = next_pc(br_taken, br_target, pc_r);
                    end
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_HALT: begin
                halted_s = 1'b1;
                valid_s  = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                instr_s = NOP_INSTR;
                valid_s = 1'b0;
            end
        endcase
        pc_plus4_s = pc_s + 32'd4;
    end

    // State and output registers; reset aborts any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_PC;
            pc_plus4_r <= RESET_PC + 32'd4;
            instr_r    <= NOP_INSTR;
            valid_r    <= 1'b0;
            halted_r   <= 1'b0;
            req_r      <= 1'b0;
            count_r    <= 32'd0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            pc_plus4_r <= pc_plus4_s;
            instr_r    <= instr_s;
            valid_r    <= valid_s;
            halted_r   <= halted_s;
            req_r      <= req_s;
            count_r    <= count_s;
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign opcode      = instr_r[6:0];
    assign funct3      = instr_r[14:12];
    assign funct7      = instr_r[31:25];
    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_r;
    assign instr_valid = valid_r;
    assign halted      = halted_r;
    assign instr_count = count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: randomized memory latency, ack, redirect and halt traffic checked
// every cycle against a transaction-level model, plus directed pins of known values.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_ack = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'd0;
    logic        hlt = 1'b0;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        halted;
    logic [31:0] instr_count;

    int total = 0;
    int bad = 0;

    int lat_min = 1;
    int lat_max = 1;
    int ack_pct = 100;
    int hlt_div = 0;
    bit rand_ctl = 1'b0;
    bit spur = 1'b0;
    bit mem_busy = 1'b0;
    int mem_cnt = 0;
    bit mon_on = 1'b0;

    bit          m_started = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_halted = 1'b0;
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_instr = NOP;
    logic [31:0] m_count = 32'd0;

    fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_ack(instr_ack), .br_taken(br_taken), .br_target(br_target), .hlt(hlt),
        .instr(instr), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .pc(pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid),
        .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0050_0093;
        else if (a == 32'h0000_0004) return 32'h00A0_0113;
        else return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Memory responder and random control driving, all on the falling edge.
    task automatic step();
        @(negedge clk);
        imem_rvalid = 1'b0;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(imem_addr);
                mem_busy    = 1'b0;
            end else begin
                mem_cnt--;
            end
        end else if (imem_req) begin
            mem_busy = 1'b1;
            mem_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
        end else if (spur && ($urandom % 32'd6 == 32'd0)) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
        end
        if (rand_ctl) begin
            instr_ack = (int'($urandom_range(99, 0)) < ack_pct);
            br_taken  = ($urandom % 32'd3 == 32'd0);
            br_target = $urandom;
            hlt       = (hlt_div > 0) && (int'($urandom_range(hlt_div - 1, 0)) == 0);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #3;
        rst_n       = 1'b0;
        mon_on      = 1'b1;
        imem_rvalid = 1'b0;
        mem_busy    = 1'b0;
        instr_ack   = 1'b0;
        br_taken    = 1'b0;
        hlt         = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_instr", instr, NOP);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_count", instr_count, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!instr_valid && n < 60) begin
            step();
            n++;
        end
        chk("wait_valid", 32'(instr_valid), 32'd1);
    endtask

    // Reference model advanced on each rising edge, compared just after it.
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_started = 1'b0;
            m_valid   = 1'b0;
            m_halted  = 1'b0;
            m_pc      = RST_PC;
            m_instr   = NOP;
            m_count   = 32'd0;
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (m_halted) begin
            m_valid = 1'b0;
        end else if (!m_valid) begin
            if (imem_rvalid) begin
                m_valid = 1'b1;
                m_instr = imem_rdata;
            end
        end else if (instr_ack) begin
            m_count = m_count + 32'd1;
            m_valid = 1'b0;
            m_instr = NOP;
            if (hlt) m_halted = 1'b1;
            else if (br_taken) m_pc = br_target & 32'hFFFF_FFFC;
            else m_pc = m_pc + 32'd4;
        end
        #1;
        if (mon_on) begin
            chk("req", 32'(imem_req), 32'(m_started && !m_valid && !m_halted));
            chk("addr", imem_addr, m_pc);
            chk("instr", instr, m_instr);
            chk("opcode", 32'(opcode), 32'(m_instr[6:0]));
            chk("funct3", 32'(funct3), 32'(m_instr[14:12]));
            chk("funct7", 32'(funct7), 32'(m_instr[31:25]));
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("valid", 32'(instr_valid), 32'(m_valid));
            chk("halted", 32'(halted), 32'(m_halted));
            chk("count", instr_count, m_count);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_dut();
        lat_min = 1; lat_max = 1;
        instr_ack = 1'b1;
        step();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, RST_PC);
        step(); step();
        chk("v0_valid", 32'(instr_valid), 32'd1);
        chk("v0_pc4", pc_plus4, 32'h0000_0000);
        step();
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        chk("cnt1", instr_count, 32'd1);
        step(); step();
        chk("i1_instr", instr, 32'h0050_0093);
        chk("i1_opcode", 32'(opcode), 32'h13);
        chk("i1_pc", pc, 32'h0000_0000);
        step();
        chk("cnt2", instr_count, 32'd2);
        step(); step();
        chk("i2_instr", instr, 32'h00A0_0113);
        chk("i2_pc", pc, 32'h0000_0004);
        br_taken = 1'b1; br_target = 32'h0000_0103;
        lat_min = 5; lat_max = 5;
        step();
        chk("br_addr", imem_addr, 32'h0000_0100);
        chk("br_cnt", instr_count, 32'd3);
        br_taken = 1'b0; instr_ack = 1'b0;
        repeat (5) step();
        chk("lat5_req", 32'(imem_req), 32'd1);
        chk("lat5_addr", imem_addr, 32'h0000_0100);
        step();
        chk("lat5_valid", 32'(instr_valid), 32'd1);
        repeat (2) step();
        chk("hold_noreq", 32'(imem_req), 32'd0);
        chk("hold_instr", instr, mem_word(32'h0000_0100));
        instr_ack = 1'b1;
        step();
        chk("cnt4", instr_count, 32'd4);
        chk("seq_addr", imem_addr, 32'h0000_0104);
        instr_ack = 1'b0; lat_min = 1; lat_max = 1;
        wait_valid();
        instr_ack = 1'b1; br_taken = 1'b1; br_target = 32'h0000_0023;
        step();
        instr_ack = 1'b0; br_taken = 1'b0;
        wait_valid();
        chk("pc20", pc, 32'h0000_0020);
        instr_ack = 1'b1; hlt = 1'b1; br_taken = 1'b1; br_target = 32'h0000_0040;
        step();
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_pc", pc, 32'h0000_0020);
        chk("halt_cnt", instr_count, 32'd6);
        rand_ctl = 1'b1; spur = 1'b1; ack_pct = 50; hlt_div = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("halt_noreq", 32'(imem_req), 32'd0);
        end
        chk("halt_sticky", 32'(halted), 32'd1);
        chk("halt_cnt_end", instr_count, 32'd6);
        rand_ctl = 1'b0; spur = 1'b0;

        reset_dut();
        lat_min = 4; lat_max = 4;
        instr_ack = 1'b0;
        step(); step();
        chk("midfetch_req", 32'(imem_req), 32'd1);
        reset_dut();
        step();
        chk("restart_addr", imem_addr, RST_PC);
        wait_valid();
        chk("restart_instr", instr, mem_word(RST_PC));

        for (int e = 0; e < 6; e++) begin
            reset_dut();
            rand_ctl = 1'b1; spur = 1'b1;
            lat_min = 1; lat_max = 1 + e;
            ack_pct = 30 + 10 * e;
            hlt_div = (e % 2 == 1) ? 60 : 0;
            for (int i = 0; i < 400; i++) begin
                step();
                if ($urandom % 32'd200 == 32'd0) reset_dut();
            end
        end
        rand_ctl = 1'b0; spur = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
